// File: rtl/seq_normalizer.sv
// seq_normalizer: multi-cycle normalizer that undoes a barrel shift.
// It moves the leading one (dir=0, toward bit 31) or the trailing one
// (dir=1, toward bit 0) to the word edge. It reports the normalized word,
// the number of positions removed, and a zero flag.
// Optional feature: define NORM_NIBBLE_EN to allow 4-bit steps whenever the
// nibble nearest the target edge is all zero. The results are unchanged and
// the latency is shorter.
module seq_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  input  logic        dir,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] norm,
  output logic [4:0]  shamt,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] work;
  logic        dir_r;
  logic [4:0]  cnt;
  logic        accept;
  logic        tgt_set;
  logic        fin;
  logic [2:0]  amt;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign tgt_set   = dir_r ? work[0] : work[31];

`ifdef NORM_NIBBLE_EN
  logic nib_clr;
  assign nib_clr = dir_r ? (work[3:0] == 4'd0) : (work[31:28] == 4'd0);
`endif

  // Move one bit (or one nibble) toward the target edge, filling with zeros.
  function automatic logic [31:0] step_toward(input logic [31:0] w,
                                              input logic        d,
                                              input logic [2:0]  n);
    step_toward = d ? (w >> n) : (w << n);
  endfunction

  // State register: only control state is reset.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and the per-cycle step decision made in SHIFT.
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    amt     = 3'd0;
    case (state)
      IDLE: begin
        if (accept) state_n = (data == 32'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (tgt_set) begin
          fin     = 1'b1;
          state_n = DONE;
        end else begin
`ifdef NORM_NIBBLE_EN
          if (nib_clr) amt = 3'd4;
          else         amt = 3'd1;
`else
          amt = 3'd1;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Working word and counter. They are not reset because accept reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      work  <= data;
      dir_r <= dir;
      cnt   <= 5'd0;
    end else if (amt != 3'd0) begin
      work <= step_toward(work, dir_r, amt);
      cnt  <= cnt + {2'b00, amt};
    end
  end

  // Result registers. They change only on entering DONE or on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      norm  <= 32'd0;
      shamt <= 5'd0;
      zero  <= 1'b0;
    end else if (accept && (data == 32'd0)) begin
      norm  <= 32'd0;
      shamt <= 5'd0;
      zero  <= 1'b1;
    end else if (fin) begin
      norm  <= work;
      shamt <= cnt;
      zero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// tb_seq_normalizer: scoreboard bench for seq_normalizer.
// The driver pushes the expected results into a queue. The monitor compares
// the queued results against each output presented by the DUT. The monitor
// also drives out_ready and checks the values after reset.
module tb_seq_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data = 32'd0;
  logic        dir = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] norm;
  logic [4:0]  shamt;
  logic        zero;

  seq_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
    .norm(norm), .shamt(shamt), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] norm;
    logic [4:0]  shamt;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: hold off 5 cycles
  bit   finish_req = 1'b0;

  // Reference model: locate the edge-most one directly and shift by distance.
  function automatic exp_t model(input logic [31:0] d, input logic dr);
    exp_t e;
    int   s;
    s      = 0;
    e.norm = 32'd0;
    e.zero = (d == 32'd0);
    e.lat  = 1;
    e.acc  = 0;
    if (d != 32'd0) begin
      if (!dr) begin
        for (int b = 0; b < 32; b++) if (d[b]) s = 31 - b;
        e.norm = d << s;
      end else begin
        for (int b = 31; b >= 0; b--) if (d[b]) s = b;
        e.norm = d >> s;
      end
`ifdef NORM_NIBBLE_EN
      e.lat = s / 4 + s % 4 + 2;
`else
      e.lat = s + 2;
`endif
    end
    e.shamt = s[4:0];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: drives the consumer side, checks the results and the values after reset.
  bit   prev_v = 1'b0;
  bit   rst_d = 1'b1;
  int   vcnt = 0;
  exp_t e;
  always @(negedge clk) begin
    if (finish_req) begin
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      prev_v    = 1'b0;
      vcnt      = 0;
      out_ready = 1'b1;
      rst_d     = 1'b1;
    end else begin
      if (rst_d) begin
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_norm", norm, 32'd0);
        chk("post_rst_shamt", 32'(shamt), 32'd0);
        chk("post_rst_zero", 32'(zero), 32'd0);
      end
      rst_d = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          out_ready = 1'b1;
        end else begin
          e = q[0];
          if (!prev_v) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          vcnt++;
          if (rdy_mode == 2)      out_ready = (vcnt > 5);
          else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
          else                    out_ready = 1'b1;
          chk("norm", norm, e.norm);
          chk("shamt", 32'(shamt), 32'(e.shamt));
          chk("zero", 32'(zero), 32'(e.zero));
          if (out_ready) e = q.pop_front();
        end
        prev_v = 1'b1;
      end else begin
        prev_v    = 1'b0;
        vcnt      = 0;
        out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Offer one word. With junk set, in_valid stays high with data=1 while the block is busy.
  task automatic send(input logic [31:0] d, input logic dr, input bit junk);
    exp_t x;
    int   t;
    @(negedge clk);
    in_valid = 1'b1;
    data     = d;
    dir      = dr;
    t        = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        $display("FAIL send_timeout in_ready=0 after %0d cycles, required 1", t);
        $fatal(1, "in_ready never rose");
      end
    end
    x     = model(d, dr);
    x.acc = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (junk) begin
      data = 32'h1;
      dir  = 1'b0;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  logic [31:0] w;
  logic [31:0] r;
  logic        rd;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Extremes and zero
    send(32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 1'b1, 1'b0);
    send(32'h0000_0001, 1'b1, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Backpressure while in_valid is held high during the busy period
    rdy_mode = 2;
    send(32'h00F0_0000, 1'b0, 1'b1);
    send(32'h0000_0001, 1'b0, 1'b0);
    drain();
    rdy_mode = 0;

    // Reset in the middle of SHIFT, then a clean rerun of the same word
    send(32'h0000_0100, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h0000_0100, 1'b0, 1'b0);
    drain();

    // Round trip of shifter outputs i << k
    for (int i = 1; i <= 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        w = 32'(i) << ((j == 2) ? 31 : j);
        if (w != 32'd0) send(w, 1'b0, 1'b0);
      end
    end
    drain();

    // Random words, both directions, random consumer stalls
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      rd = 1'($urandom_range(0, 1));
      w  = rd ? (r << $urandom_range(0, 31)) : (r >> $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) w = 32'd0;
      send(w, rd, 1'b0);
    end
    drain();
    finish_req = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
